// File: rtl/hex_display_scan_pkg.sv
// rtl/hex_display_scan_pkg.sv - shared segment constants for the hex display scanner
//
// Purpose : segment-off pattern and the 16-entry active-low hex glyph table.
// Ports   : none (package).
package hex_display_scan_pkg;

    // Active-low: all ones means every segment is dark.
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Glyphs in a..g order (bit6=a ... bit0=g), active-low.
    // Listed from F down to 0 so that HEX_GLYPHS[n] selects the glyph for n.
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'b0111000,   // F
        7'b0110000,   // E
        7'b1000010,   // d
        7'b0110001,   // C
        7'b1100000,   // b
        7'b0001000,   // A
        7'b0000100,   // 9
        7'b0000000,   // 8
        7'b0001101,   // 7
        7'b0100000,   // 6
        7'b0100100,   // 5
        7'b1001100,   // 4
        7'b0000110,   // 3
        7'b0010010,   // 2
        7'b1001111,   // 1
        7'b0000001    // 0
    };

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational hex nibble to active-low 7-segment decoder
//
// Purpose : maps one hex nibble to its segment pattern.
// Ports   : nibble (in, 4)  hex digit to show
//           seg    (out, 7) active-low segments, bit6=a ... bit0=g
module hex_seg_decode
    import hex_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - time-multiplexed multi-digit hex 7-segment driver
//
// Purpose : latches a DIGITS-nibble value and scans it one digit at a time onto a
//           shared active-low segment bus, with per-digit blanking, leading-zero
//           suppression and whole-display blinking.
// Ports   : clock       (in, 1)          system clock
//           reset       (in, 1)          asynchronous active-high reset
//           value       (in, 4*DIGITS)   hex value, nibble i = digit i
//           load        (in, 1)          capture value this cycle
//           blank_mask  (in, DIGITS)     bit i forces digit i dark (live)
//           lz_suppress (in, 1)          blank leading zero digits (live)
//           blink_en    (in, 1)          blink the whole display
//           seg         (out, 7)         active-low segments, bit6=a ... bit0=g
//           dig_sel     (out, DIGITS)    active-low one-hot digit enable
module hex_display_scan
    import hex_display_scan_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_SCANS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int DIV_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRAME_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(BLINK_SCANS - 1);
    localparam logic [DIGITS-1:0]  DIG_ONE   = DIGITS'(1);

    logic [DIGITS-1:0][3:0] value_q;
    logic [DIV_W-1:0]       div_cnt;
    logic [IDX_W-1:0]       idx;
    logic [FRAME_W-1:0]     frame_cnt;
    logic                   blink_ph;
    // Low until the first tick after reset: that tick shows digit 0 rather than
    // advancing past it, so the scan always starts from the least significant digit.
    logic                   scan_run;

    logic                   tick;
    logic                   frame_end;
    logic [IDX_W-1:0]       idx_nxt;
    logic [FRAME_W-1:0]     frame_nxt;
    logic                   blink_ph_nxt;
    logic                   upper_zero;
    logic                   dark;
    logic [3:0]             nibble;
    logic [6:0]             glyph;

    assign tick      = (div_cnt == DIV_MAX);
    assign frame_end = tick && scan_run && (idx == IDX_MAX);

    always_comb begin
        idx_nxt = idx;
        if (tick && scan_run) begin
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
        end
    end

    always_comb begin
        frame_nxt    = frame_cnt;
        blink_ph_nxt = blink_ph;
        if (frame_end) begin
            if (frame_cnt == FRAME_MAX) begin
                frame_nxt    = '0;
                blink_ph_nxt = ~blink_ph;
            end else begin
                frame_nxt = frame_cnt + FRAME_W'(1);
            end
        end
    end

    // True when digit idx_nxt and every more significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx_nxt)) && (value_q[i] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Blink phase is taken from its next value so dark/lit changes line up with
    // the start of a frame (digit 0) rather than one slot into it.
    assign dark = blank_mask[idx_nxt]
               || (lz_suppress && (idx_nxt != '0) && upper_zero)
               || (blink_en && blink_ph_nxt);

    // Current value_q is used, so a load coinciding with a tick only affects
    // later slots.
    assign nibble = value_q[idx_nxt];

    hex_seg_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q   <= '0;
            div_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
            scan_run  <= 1'b0;
            seg       <= SEG_OFF;
            dig_sel   <= '1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (load) begin
                value_q <= value;
            end
            if (tick) begin
                idx       <= idx_nxt;
                scan_run  <= 1'b1;
                frame_cnt <= frame_nxt;
                blink_ph  <= blink_ph_nxt;
                seg       <= dark ? SEG_OFF : glyph;
                dig_sel   <= dark ? '1 : ~(DIG_ONE << idx_nxt);
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - self-checking bench for hex_display_scan
module tb_hex_display_scan;

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic        blink_en;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int checks;
    int errors;

    hex_display_scan #(
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .BLINK_SCANS (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .value       (value),
        .load        (load),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .blink_en    (blink_en),
        .seg         (seg),
        .dig_sel     (dig_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [6:0] OFF = 7'b1111111;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reset, load v on the first clock after release; returns at the negedge one
    // cycle after release, so step(3) lands just after the first tick (digit 0).
    task automatic restart(input logic [15:0] v);
        @(negedge clock);
        reset = 1'b1;
        value = v;
        load  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic test_reset();
        restart(16'h12AF);
        step(2);
        checks++;
        if ({seg, dig_sel} !== {OFF, 4'b1111}) begin
            errors++;
            $display("FAIL reset_pre_tick: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", seg, dig_sel, OFF, 4'b1111);
        end
        step(1);
        checks++;
        if ({seg, dig_sel} !== {7'b0111000, 4'b1110}) begin
            errors++;
            $display("FAIL reset_first_tick: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", seg, dig_sel, 7'b0111000, 4'b1110);
        end
        step(6);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({seg, dig_sel} !== {OFF, 4'b1111}) begin
            errors++;
            $display("FAIL reset_async: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", seg, dig_sel, OFF, 4'b1111);
        end
        @(negedge clock);
        reset = 1'b0;
        step(4);
        // value_q was cleared by reset, so digit 0 shows "0"
        checks++;
        if ({seg, dig_sel} !== {7'b0000001, 4'b1110}) begin
            errors++;
            $display("FAIL reset_release_digit0: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", seg, dig_sel, 7'b0000001, 4'b1110);
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [5] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111, 7'b0111000};
        logic [3:0] exp_dig [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        restart(16'h12AF);
        step(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({seg, dig_sel} !== {exp_seg[i], exp_dig[i]}) begin
                errors++;
                $display("FAIL scan slot %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", i, seg, dig_sel, exp_seg[i], exp_dig[i]);
            end
            // mid-slot hold check
            step(2);
            checks++;
            if ({seg, dig_sel} !== {exp_seg[i], exp_dig[i]}) begin
                errors++;
                $display("FAIL scan_hold slot %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", i, seg, dig_sel, exp_seg[i], exp_dig[i]);
            end
            step(2);
        end
    endtask

    task automatic test_leading_zeros();
        logic [6:0] exp_seg_a [4] = '{7'b0000001, 7'b0100100, OFF, OFF};
        logic [3:0] exp_dig_a [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic [6:0] exp_seg_b [4] = '{7'b0000001, OFF, OFF, OFF};
        logic [3:0] exp_dig_b [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        lz_suppress = 1'b1;
        restart(16'h0050);
        step(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({seg, dig_sel} !== {exp_seg_a[i], exp_dig_a[i]}) begin
                errors++;
                $display("FAIL lz_0050 digit %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", i, seg, dig_sel, exp_seg_a[i], exp_dig_a[i]);
            end
            step(4);
        end
        restart(16'h0000);
        step(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({seg, dig_sel} !== {exp_seg_b[i], exp_dig_b[i]}) begin
                errors++;
                $display("FAIL lz_0000 digit %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", i, seg, dig_sel, exp_seg_b[i], exp_dig_b[i]);
            end
            step(4);
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_blank_mask();
        logic [6:0] exp_seg [4] = '{OFF, 7'b0000000, OFF, 7'b0000000};
        logic [3:0] exp_dig [4] = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
        blank_mask = 4'b0101;
        restart(16'h8888);
        step(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({seg, dig_sel} !== {exp_seg[i], exp_dig[i]}) begin
                errors++;
                $display("FAIL blank digit %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", i, seg, dig_sel, exp_seg[i], exp_dig[i]);
            end
            step(4);
        end
        blank_mask = 4'b0000;
    endtask

    task automatic test_blink();
        logic [6:0] scan_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        logic [3:0] scan_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] es;
        logic [3:0] ed;
        blink_en = 1'b1;
        restart(16'h12AF);
        step(3);
        // frames 0,1 lit, 2,3 dark, 4 lit
        for (int k = 0; k < 20; k++) begin
            if (((k / 4) / 2) % 2 == 0) begin
                es = scan_seg[k % 4];
                ed = scan_dig[k % 4];
            end else begin
                es = OFF;
                ed = 4'b1111;
            end
            checks++;
            if ({seg, dig_sel} !== {es, ed}) begin
                errors++;
                $display("FAIL blink slot %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", k, seg, dig_sel, es, ed);
            end
            step(4);
        end
        // slot 20 (frame 5) lit; disable before frames 6,7 which would be dark
        blink_en = 1'b0;
        for (int k = 20; k < 32; k++) begin
            checks++;
            if ({seg, dig_sel} !== {scan_seg[k % 4], scan_dig[k % 4]}) begin
                errors++;
                $display("FAIL blink_off slot %0d: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", k, seg, dig_sel, scan_seg[k % 4], scan_dig[k % 4]);
            end
            step(4);
        end
    endtask

    task automatic test_load_tick_collision();
        restart(16'h12AF);
        step(3);
        // next tick is at the following posedge after three more negedges
        step(3);
        value = 16'hFFFF;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        checks++;
        if ({seg, dig_sel} !== {7'b0001000, 4'b1101}) begin
            errors++;
            $display("FAIL collision_old_slot: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", seg, dig_sel, 7'b0001000, 4'b1101);
        end
        step(4);
        checks++;
        if ({seg, dig_sel} !== {7'b0111000, 4'b1011}) begin
            errors++;
            $display("FAIL collision_new_slot: seg=%b dig_sel=%b expected seg=%b dig_sel=%b", seg, dig_sel, 7'b0111000, 4'b1011);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        value       = 16'h0000;
        load        = 1'b0;
        blank_mask  = 4'b0000;
        lz_suppress = 1'b0;
        blink_en    = 1'b0;
        step(2);
        reset = 1'b0;

        test_reset();
        test_scan();
        test_leading_zeros();
        test_blank_mask();
        test_blink();
        test_load_tick_collision();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
